// File: rtl/conv_result_streamer.sv
// Captures a conv_top result frame on each conv_fin rising edge and streams it out in raster order.
// Optional build macro CONV_RESULT_RELU_EN clamps negative elements to zero in the output register.
module conv_result_streamer #(
    parameter int RESULT_WIDTH  = 3,
    parameter int RESULT_HEIGHT = 3,
    parameter int BITWIDTH      = 3,
    parameter int EXPAND        = 1,
    localparam int ELEM_W = 2 * EXPAND * BITWIDTH,
    localparam int N_ELEM = RESULT_WIDTH * RESULT_HEIGHT,
    localparam int ROW_W  = (RESULT_HEIGHT > 1) ? $clog2(RESULT_HEIGHT) : 1,
    localparam int COL_W  = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1
) (
    input  logic                     clk_en,
    input  logic                     rst_n,
    input  logic                     conv_fin,
    input  logic [ELEM_W*N_ELEM-1:0] result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(RESULT_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(RESULT_WIDTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state, state_nx;
    logic                       fin_d;
    logic                       start, xfer, at_last, load, ovr_set;
    logic [ROW_W-1:0]           row, row_nx;
    logic [COL_W-1:0]           col, col_nx;
    logic [ELEM_W*N_ELEM-1:0]   shadow_p0, shadow_nx;
    logic [ELEM_W-1:0]          elem [RESULT_HEIGHT][RESULT_WIDTH];
    logic [ELEM_W-1:0]          data_nx;

`ifdef CONV_RESULT_RELU_EN
    function automatic logic [ELEM_W-1:0] relu_clamp(input logic signed [ELEM_W-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction
`endif

    assign start   = conv_fin & ~fin_d;
    assign at_last = (state == STREAM) && (row == ROW_MAX) && (col == COL_MAX);
    assign xfer    = (state == STREAM) && out_ready;

    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        load     = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    row_nx   = '0;
                    col_nx   = '0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    row_nx = '0;
                    col_nx = '0;
                    // A start coinciding with the final handshake chains straight into the next frame.
                    if (start) load = 1'b1;
                    else       state_nx = IDLE;
                end else begin
                    if (xfer) begin
                        if (col == COL_MAX) begin
                            col_nx = '0;
                            row_nx = row + 1'b1;
                        end else begin
                            col_nx = col + 1'b1;
                        end
                    end
                    if (start) ovr_set = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output mux looks ahead at the next index so out_data is registered with no extra latency.
    always_comb begin
        shadow_nx = load ? result : shadow_p0;
        for (int r = 0; r < RESULT_HEIGHT; r++) begin
            for (int c = 0; c < RESULT_WIDTH; c++) begin
                elem[r][c] = shadow_nx[(r * RESULT_WIDTH + c) * ELEM_W +: ELEM_W];
            end
        end
`ifdef CONV_RESULT_RELU_EN
        data_nx = relu_clamp(elem[row_nx][col_nx]);
`else
        data_nx = elem[row_nx][col_nx];
`endif
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            state     <= IDLE;
            fin_d     <= 1'b0;
            row       <= '0;
            col       <= '0;
            shadow_p0 <= '0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            fin_d     <= conv_fin;
            row       <= row_nx;
            col       <= col_nx;
            shadow_p0 <= shadow_nx;
            out_data  <= data_nx;
            if (ovr_set) overrun <= 1'b1;
        end
    end

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_last  = at_last;
    assign out_row   = row;
    assign out_col   = col;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Scoreboard bench for conv_result_streamer: frame-level model pushes expected elements, negedge monitor checks.
module tb_conv_result_streamer;

    localparam int RW = 3;
    localparam int RH = 3;
    localparam int EW = 6;
    localparam int NE = RW * RH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            conv_fin = 1'b0;
    logic [EW*NE-1:0] result = '0;
    logic            out_ready = 1'b0;
    logic            out_valid, out_last, busy, overrun;
    logic [EW-1:0]   out_data;
    logic [1:0]      out_row, out_col;

    conv_result_streamer #(.RESULT_WIDTH(RW), .RESULT_HEIGHT(RH), .BITWIDTH(3), .EXPAND(1)) dut (
        .clk_en(clk), .rst_n(rst_n), .conv_fin(conv_fin), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] d;
        int            r;
        int            c;
        bit            l;
    } exp_t;

    exp_t exp_q[$];
    int   rem = 0;
    bit   m_ovr = 1'b0;
    bit   prev_fin = 1'b0;
    bit   m_xfer, m_start;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [EW-1:0] expect_elem(input logic [EW-1:0] x);
`ifdef CONV_RESULT_RELU_EN
        return x[EW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: a frame is a list of 9 elements; accepted only when nothing remains to drain.
    always @(posedge clk) begin
        if (!rst_n) begin
            rem      = 0;
            m_ovr    = 1'b0;
            prev_fin = 1'b0;
            exp_q.delete();
        end else begin
            m_xfer   = (rem > 0) && out_ready;
            m_start  = conv_fin && !prev_fin;
            prev_fin = conv_fin;
            if (m_xfer) rem--;
            if (m_start) begin
                if (rem == 0) begin
                    rem = NE;
                    for (int k = 0; k < NE; k++) begin
                        exp_t e;
                        e.d = expect_elem(result[k*EW +: EW]);
                        e.r = k / RW;
                        e.c = k % RW;
                        e.l = (k == NE - 1);
                        exp_q.push_back(e);
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(out_valid), 32'(rem > 0));
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("data", 32'(out_data), 32'(exp_q[0].d));
                    chk("row", 32'(out_row), 32'(exp_q[0].r));
                    chk("col", 32'(out_col), 32'(exp_q[0].c));
                    chk("last", 32'(out_last), 32'(exp_q[0].l));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [EW-1:0] v [NE]);
        for (int k = 0; k < NE; k++) result[k*EW +: EW] = v[k];
    endtask

    task automatic set_seq(input int base);
        for (int k = 0; k < NE; k++) result[k*EW +: EW] = EW'(base + k);
    endtask

    task automatic pulse_fin();
        conv_fin = 1'b1;
        step(1);
        conv_fin = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_col", 32'(out_col), 32'd0);
        step(1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((rem > 0 || exp_q.size() > 0) && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_timeout", 32'(rem + exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [EW-1:0] fr [NE];
        conv_fin = 1'b0;
        out_ready = 1'b0;
        step(2);
        do_reset();

        // basic frame
        set_seq(1);
        out_ready = 1'b1;
        pulse_fin();
        step(12);

        // backpressure 1,0,0
        set_seq(10);
        pulse_fin();
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 3 == 0);
            step(1);
        end
        drain(50);

        // overrun after 4 elements
        set_seq(1);
        out_ready = 1'b1;
        pulse_fin();
        step(4);
        result = {NE{6'h3F}};
        pulse_fin();
        drain(50);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        do_reset();

        // back-to-back with final handshake
        set_seq(20);
        out_ready = 1'b1;
        conv_fin = 1'b1;
        step(1);
        conv_fin = 1'b0;
        step(8);
        set_seq(40);
        conv_fin = 1'b1;
        step(1);
        conv_fin = 1'b0;
        drain(50);
        chk("b2b_no_overrun", 32'(overrun), 32'd0);

        // level conv_fin
        set_seq(30);
        conv_fin = 1'b1;
        step(20);
        conv_fin = 1'b0;
        drain(50);

        // reset mid-frame, then fresh start
        set_seq(50);
        pulse_fin();
        step(4);
        do_reset();
        set_seq(3);
        pulse_fin();
        drain(50);

        // sign-boundary elements
        for (int k = 0; k < NE; k++) fr[k] = EW'(k);
        fr[0] = 6'h20;
        fr[1] = 6'h3F;
        fr[2] = 6'h1F;
        set_frame(fr);
        pulse_fin();
        drain(50);
        do_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            conv_fin  = ($urandom_range(0, 7) == 0);
            out_ready = $urandom_range(0, 1);
            for (int k = 0; k < NE; k++) result[k*EW +: EW] = EW'($urandom);
            step(1);
        end
        conv_fin = 1'b0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
